// File: rtl/lock_controller.sv
// lock_controller: keypad sequencing for the digital lock.
// Collects four digits, compares them with the stored combination and runs the
// open / error / lockout dwell periods. The display word and status flags are
// registered copies of what the next state will show.
module lock_controller #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned OPEN_CYCLES    = 250_000_000,
  parameter int unsigned ERR_CYCLES     = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter logic [4:0]  DASH_CODE      = 5'd16,
  parameter logic [4:0]  ERR_CODE       = 5'd14,
  parameter logic [4:0]  BLANK_CODE     = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        digit_valid,
  input  logic [3:0]  digit_in,
  input  logic        enter,
  input  logic        clear,
  input  logic        set_mode,
  output logic [19:0] big_bin,
  output logic        unlocked,
  output logic        locked_out,
  output logic [1:0]  fail_count
);

  localparam int unsigned TIMER_W = 30;
  localparam int unsigned SLOTS   = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_PROGRAM = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;
  localparam logic [2:0] S_LOCKOUT = 3'd6;

  logic [2:0]         state, state_n;
  logic [15:0]        entry_buf, entry_buf_n;
  logic [2:0]         cnt, cnt_n;
  logic [15:0]        code_reg, code_reg_n;
  logic [1:0]         fail_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [19:0]        big_bin_n;
  logic [4:0]         slot;
  logic               digit_ok;
  logic               timer_done;

  // A digit is usable only if it is decimal and a slot is still free.
  assign digit_ok   = digit_valid && (digit_in <= 4'd9) && (cnt != 3'd4);
  assign timer_done = (timer == TIMER_W'(0));

  // State, buffer, code, timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      entry_buf  <= 16'h0000;
      cnt        <= 3'd0;
      code_reg   <= DEFAULT_CODE;
      fail_count <= 2'd0;
      timer      <= TIMER_W'(0);
      big_bin    <= {SLOTS{DASH_CODE}};
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      entry_buf  <= entry_buf_n;
      cnt        <= cnt_n;
      code_reg   <= code_reg_n;
      fail_count <= fail_n;
      timer      <= timer_n;
      big_bin    <= big_bin_n;
      unlocked   <= (state_n == S_OPEN) || (state_n == S_PROGRAM);
      locked_out <= (state_n == S_LOCKOUT);
    end
  end

  // Next-state, buffer handling (clear > enter > digit) and next display word.
  always_comb begin
    state_n     = state;
    entry_buf_n = entry_buf;
    cnt_n       = cnt;
    code_reg_n  = code_reg;
    fail_n      = fail_count;
    timer_n     = timer;
    big_bin_n   = {SLOTS{DASH_CODE}};
    slot        = DASH_CODE;

    case (state)
      S_IDLE: begin
        if (!clear && !enter && digit_ok) begin
          entry_buf_n = {entry_buf[11:0], digit_in};
          cnt_n       = cnt + 3'd1;
          state_n     = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (clear) begin
          entry_buf_n = 16'h0000;
          cnt_n       = 3'd0;
          state_n     = S_IDLE;
        end else if (enter) begin
          if (cnt == 3'd4) state_n = S_CHECK;
        end else if (digit_ok) begin
          entry_buf_n = {entry_buf[11:0], digit_in};
          cnt_n       = cnt + 3'd1;
        end
      end
      S_CHECK: begin
        if (entry_buf == code_reg) begin
          fail_n  = 2'd0;
          timer_n = TIMER_W'(OPEN_CYCLES - 1);
          state_n = S_OPEN;
        end else if ((32'(fail_count) + 32'd1) == MAX_FAILS) begin
          fail_n  = 2'd0;
          timer_n = TIMER_W'(LOCKOUT_CYCLES - 1);
          state_n = S_LOCKOUT;
        end else begin
          fail_n  = fail_count + 2'd1;
          timer_n = TIMER_W'(ERR_CYCLES - 1);
          state_n = S_ERROR;
        end
      end
      S_OPEN: begin
        if (timer_done) begin
          entry_buf_n = 16'h0000;
          cnt_n       = 3'd0;
          state_n     = S_IDLE;
        end else if (set_mode) begin
          entry_buf_n = 16'h0000;
          cnt_n       = 3'd0;
          timer_n     = TIMER_W'(0);
          state_n     = S_PROGRAM;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      S_PROGRAM: begin
        if (clear) begin
          entry_buf_n = 16'h0000;
          cnt_n       = 3'd0;
        end else if (enter) begin
          if (cnt == 3'd4) begin
            code_reg_n  = entry_buf;
            entry_buf_n = 16'h0000;
            cnt_n       = 3'd0;
            state_n     = S_IDLE;
          end
        end else if (digit_ok) begin
          entry_buf_n = {entry_buf[11:0], digit_in};
          cnt_n       = cnt + 3'd1;
        end
      end
      S_ERROR, S_LOCKOUT: begin
        if (timer_done) begin
          entry_buf_n = 16'h0000;
          cnt_n       = 3'd0;
          state_n     = S_IDLE;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      default: begin
        entry_buf_n = 16'h0000;
        cnt_n       = 3'd0;
        timer_n     = TIMER_W'(0);
        state_n     = S_IDLE;
      end
    endcase

    // Slot 0 is the rightmost field and holds the most recent digit.
    for (int i = 0; i < int'(SLOTS); i++) begin
      if (state_n == S_ERROR)             slot = ERR_CODE;
      else if (state_n == S_LOCKOUT)      slot = BLANK_CODE;
      else if (3'(i) < cnt_n)             slot = {1'b0, entry_buf_n[4*i +: 4]};
      else if (state_n == S_PROGRAM)      slot = BLANK_CODE;
      else                                slot = DASH_CODE;
      big_bin_n[5*i +: 5] = slot;
    end
  end

endmodule
